// File: rtl/mu_bus_controller.sv
// Memory-unit bus controller for the B323 CPU memory port.
// Decodes single-word CPU requests to SDRAM, boot ROM, internal I/O registers
// or unmapped space, returns read data on q and raises sticky bus errors.
// Ports:
//   clk, reset (async, active-low)
//   CPU side : address, data, we, start -> q, busy
//   ROM side : rom_addr -> rom_q (one-cycle synchronous read)
//   SDRAM    : sdram_addr, sdram_data, sdram_we, sdram_req <- sdram_ack, sdram_q
//   errors   : err_unmapped, err_timeout (sticky, cleared by a STATUS write)
module mu_bus_controller #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [26:0] address,
    input  logic [31:0] data,
    input  logic        we,
    input  logic        start,
    output logic [31:0] q,
    output logic        busy,
    output logic [8:0]  rom_addr,
    input  logic [31:0] rom_q,
    output logic [25:0] sdram_addr,
    output logic [31:0] sdram_data,
    output logic        sdram_we,
    output logic        sdram_req,
    input  logic        sdram_ack,
    input  logic [31:0] sdram_q,
    output logic        err_unmapped,
    output logic        err_timeout
);

    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [31:0] TIMEOUT_Q = 32'hDEADBEEF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ROM_WAIT = 3'd1,
        ROM_DONE = 3'd2,
        SDRAM    = 3'd3,
        FINISH   = 3'd4
    } state_t;

    state_t             state, state_next;
    logic [25:0]        addr_r;
    logic [31:0]        data_r;
    logic               we_r;
    logic [31:0]        rd_val, rd_val_next;
    logic [31:0]        scratch, scratch_next;
    logic [31:0]        cycles;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [31:0]        q_next;
    logic               busy_next, req_next, eu_next, et_next, lat_en;

    // Address decode of the incoming request (only used in IDLE)
    logic hit_sdram, hit_rom, hit_io;
    assign hit_sdram = ~address[26];
    assign hit_rom   = address[26] & (address[25:9] == 17'h0);
    assign hit_io    = address[26] & (address[25:4] == 22'h20);

    assign rom_addr   = addr_r[8:0];
    assign sdram_addr = addr_r;
    assign sdram_data = data_r;
    assign sdram_we   = we_r;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; ack takes priority over timeout
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) begin
                if (hit_sdram)    state_next = SDRAM;
                else if (hit_rom) state_next = ROM_WAIT;
                else              state_next = FINISH;
            end
            ROM_WAIT: state_next = ROM_DONE;
            ROM_DONE: state_next = IDLE;
            FINISH:   state_next = IDLE;
            SDRAM: if (sdram_ack || cnt == CNT_LAST) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        q_next       = q;
        busy_next    = busy;
        req_next     = sdram_req;
        eu_next      = err_unmapped;
        et_next      = err_timeout;
        rd_val_next  = rd_val;
        scratch_next = scratch;
        cnt_next     = cnt;
        lat_en       = 1'b0;
        case (state)
            IDLE: if (start) begin
                lat_en    = 1'b1;
                busy_next = 1'b1;
                cnt_next  = '0;
                if (hit_sdram) begin
                    req_next = 1'b1;
                end else if (!hit_rom) begin
                    rd_val_next = '0;
                    if (hit_io) begin
                        case (address[3:0])
                            4'h0: if (we) scratch_next = data;
                                  else    rd_val_next  = scratch;
                            4'h1: if (!we) rd_val_next = cycles;
                            4'h2: if (we) begin
                                      eu_next = 1'b0;
                                      et_next = 1'b0;
                                  end else begin
                                      rd_val_next = {30'b0, err_timeout, err_unmapped};
                                  end
                            default: ;
                        endcase
                    end else begin
                        eu_next = 1'b1;
                    end
                end
            end
            ROM_DONE: begin
                q_next    = we_r ? 32'h0 : rom_q;
                busy_next = 1'b0;
            end
            FINISH: begin
                q_next    = rd_val;
                busy_next = 1'b0;
            end
            SDRAM: begin
                cnt_next = CNT_W'(cnt + 1'b1);
                if (sdram_ack) begin
                    q_next    = we_r ? 32'h0 : sdram_q;
                    req_next  = 1'b0;
                    busy_next = 1'b0;
                end else if (cnt == CNT_LAST) begin
                    q_next    = TIMEOUT_Q;
                    req_next  = 1'b0;
                    et_next   = 1'b1;
                    busy_next = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q            <= '0;
            busy         <= 1'b0;
            sdram_req    <= 1'b0;
            err_unmapped <= 1'b0;
            err_timeout  <= 1'b0;
            rd_val       <= '0;
            scratch      <= '0;
            cnt          <= '0;
            addr_r       <= '0;
            data_r       <= '0;
            we_r         <= 1'b0;
        end else begin
            q            <= q_next;
            busy         <= busy_next;
            sdram_req    <= req_next;
            err_unmapped <= eu_next;
            err_timeout  <= et_next;
            rd_val       <= rd_val_next;
            scratch      <= scratch_next;
            cnt          <= cnt_next;
            if (lat_en) begin
                addr_r <= address[25:0];
                data_r <= data;
                we_r   <= we;
            end
        end
    end

    // Free-running cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cycles <= '0;
        else        cycles <= cycles + 32'd1;
    end

endmodule
